universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with hold, shift-right, shift-left and parallel-load modes.
- Provides true and complemented outputs, as the single-bit part does, plus serial outputs at both ends.
- Includes a shift counter that pulses `done` after WIDTH consecutive shifts, for serialiser/deserialiser use.
- Sits between logic-circuit exercises and downstream serial I/O blocks (LED chains, UART-style framing).

Parameters:
- WIDTH, 8: register width in bits; legal range 2..32.
- RESET_VAL, 0: value loaded into q on reset; width WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  clock enable; when 0, the block holds, identical to mode 00.
- mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering at the MSB during shift right.
- sin_l  input  1  serial input entering at the LSB during shift left.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- notq  output  WIDTH  bitwise complement of q.
- sout_r  output  1  q[0], the bit shifted out on a right shift.
- sout_l  output  1  q[WIDTH-1], the bit shifted out on a left shift.
- done  output  1  one-cycle pulse after WIDTH shifts.

Behaviour:
- Single clock, `clk`. Reset is synchronous and active-low on `rst_n`, sampled on the rising edge of clk. Reset has priority over en and mode.
- Reset values: q=RESET_VAL, notq=~RESET_VAL, shift count=0, done=0.
- notq, sout_r and sout_l are combinational from q. notq==~q must hold in every cycle, including the cycle after reset.
- Latency: q updates on the clk edge at which en, mode, d and the sin inputs are sampled. There is no additional pipeline.
- Mode 01, shift right: q <= {sin_r, q[WIDTH-1:1]}.
- Mode 10, shift left: q <= {q[WIDTH-2:0], sin_l}.
- Mode 11, load: q <= d; shift count <= 0.
- Mode 00, or en=0: q, shift count and all other state are unchanged.
- Shift counter:
  - Width is clog2(WIDTH+1).
  - Increments on every enabled shift, in either direction.
  - If an enabled shift makes the count equal WIDTH: count wraps to 0, and done=1 for exactly the next cycle.
  - Mixed left/right shifts count together.
- done:
  - Registered, and deasserts automatically after one cycle.
  - Is 0 in any cycle not directly following the WIDTH-th shift.
  - A load or hold in the same cycle as a pending pulse does not suppress that pulse.
- Simultaneous events: a load resets the count even if the count is WIDTH-1. No done pulse is produced by a load.
- Reset mid-operation: q returns to RESET_VAL, count to 0, and any pending done pulse is cleared to 0.
- sin_r and sin_l are ignored outside their respective shift modes.
- No combinational path from inputs to q. notq, sout_r and sout_l depend only on q.

Optional Feature:
- Macro: SHIFTREG_ROTATE_EN.
- Defined:
  - Adds an input port `rot` (1 bit).
  - When rot=1 during a shift, the outgoing bit is fed back in place of the serial input: right shift gives q <= {q[0], q[WIDTH-1:1]}; left shift gives q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Rotations count toward done exactly like shifts.
  - rot is ignored in hold and load.
- Not defined: the `rot` port is absent and shifts always take sin_r/sin_l.

Test Plan (WIDTH=8, RESET_VAL=8'h00 unless stated):
- Reset:
  - Stimulus: rst_n=0 for 1 edge with mode=11, d=8'hFF.
  - Required: q=8'h00, notq=8'hFF, done=0 (reset beats load).
  - Repeat with RESET_VAL=8'hA5: q=8'hA5.
- Load then shift right:
  - Stimulus: load d=8'h81, then 1 right shift with sin_r=0.
  - Required: q=8'h40, sout_r=0.
  - Then en=0 for 3 cycles: q stays 8'h40.
- Serialise:
  - Stimulus: load 8'hB4, then 8 left shifts with sin_l=0.
  - Required: sout_l sequence before each edge is 1,0,1,1,0,1,0,0; q=8'h00 after the 8th shift; done=1 in the next cycle only.
- Load mid-count:
  - Stimulus: 7 shifts, then a load of 8'h3C, then 8 further shifts.
  - Required: no done after the 7th shift or after the load; done pulses once, after the 8th post-load shift.
- Reset mid-operation:
  - Stimulus: 8th shift on edge N, rst_n=0 on edge N+1.
  - Required: done=1 for one cycle after edge N, then 0 after edge N+1; q=8'h00; count restarts, so the next done occurs only after 8 more shifts.
- Rotate (SHIFTREG_ROTATE_EN):
  - Stimulus: load 8'h01, then rot=1 with 1 right shift.
  - Required: q=8'h80.
  - Then 7 more rotates: q=8'h01 and done pulses once.

Source files
------------

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : WIDTH-bit register with hold / shift-right / shift-left / load
//               modes, true and complemented outputs, serial outputs at both
//               ends and a done pulse after every WIDTH enabled shifts.
//               Optional macro SHIFTREG_ROTATE_EN adds a `rot` input that
//               recirculates the outgoing bit instead of taking sin_r/sin_l.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
`ifdef SHIFTREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sout_r,
  output logic             sout_l,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fill_r, fill_l;
  logic             is_shift;

`ifdef SHIFTREG_ROTATE_EN
  assign fill_r = rot ? q_q[0]       : sin_r;
  assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          q_d      = {fill_r, q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], fill_l};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Both directions share one counter; the WIDTH-th shift wraps it and arms done.
    if (is_shift) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign notq   = ~q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Self-checking bench: directed scenarios with literal expected
//               values, then randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

  localparam int W = 8;

`ifdef SHIFTREG_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, sin_r, sin_l, rot;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, notq, q2, notq2;
  logic         sout_r, sout_l, done, sout_r2, sout_l2, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d),
`ifdef SHIFTREG_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .notq(notq), .sout_r(sout_r), .sout_l(sout_l), .done(done)
  );

  universal_shift_register #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_a5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d),
`ifdef SHIFTREG_ROTATE_EN
    .rot(rot),
`endif
    .q(q2), .notq(notq2), .sout_r(sout_r2), .sout_l(sout_l2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: value as an integer, plus shifts counted since last load/reset.
  int  m;
  int  nsh;
  bit  mdone;
  bit  chk_en = 1'b0;
  int  fr, fl;

  assign fr = (ROT_ON && rot) ? (m % 2)   : int'(sin_r);
  assign fl = (ROT_ON && rot) ? (m / 128) : int'(sin_l);

  always @(posedge clk) begin
    if (!rst_n) begin
      m     <= 0;
      nsh   <= 0;
      mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (en && mode == 2'd1) begin
        m     <= (m / 2) + fr * 128;
        nsh   <= nsh + 1;
        mdone <= ((nsh + 1) % W) == 0;
      end else if (en && mode == 2'd2) begin
        m     <= (m * 2) % 256 + fl;
        nsh   <= nsh + 1;
        mdone <= ((nsh + 1) % W) == 0;
      end else if (en && mode == 2'd3) begin
        m   <= int'(d);
        nsh <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q",      32'(q),      32'(m));
      chk("notq",   32'(notq),   32'(255 - m));
      chk("sout_r", 32'(sout_r), 32'(m % 2));
      chk("sout_l", 32'(sout_l), 32'(m / 128));
      chk("done",   32'(done),   32'(mdone));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 2'd3; d = v;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] pat;
    rst_n = 1'b0; en = 1'b1; mode = 2'd3; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst_q",     32'(q),     32'h00);
    chk("rst_notq",  32'(notq),  32'hFF);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_q_a5",  32'(q2),    32'hA5);
    chk("rst_notq_a5", 32'(notq2), 32'h5A);
    rst_n = 1'b1;

    load(8'h81);
    mode = 2'd1; sin_r = 1'b0; tick();
    chk("shr_q", 32'(q), 32'h40);
    chk("shr_sout_r", 32'(sout_r), 32'h0);
    en = 1'b0; mode = 2'd2; sin_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", 32'(q), 32'h40);
    end

    load(8'hB4);
    pat = 8'hB4;
    for (int i = 0; i < W; i++) begin
      chk("ser_sout_l", 32'(sout_l), 32'(pat[W-1-i]));
      mode = 2'd2; sin_l = 1'b0; tick();
    end
    chk("ser_q", 32'(q), 32'h00);
    chk("ser_done", 32'(done), 32'h1);
    mode = 2'd0; tick();
    chk("ser_done_off", 32'(done), 32'h0);

    load(8'h5A);
    for (int i = 0; i < 7; i++) begin
      mode = 2'(1 + (i % 2)); tick();
      chk("mid_done7", 32'(done), 32'h0);
    end
    load(8'h3C);
    chk("mid_done_load", 32'(done), 32'h0);
    for (int i = 0; i < W; i++) begin
      mode = 2'd1; tick();
      chk("mid_done8", 32'(done), (i == W - 1) ? 32'h1 : 32'h0);
    end

    load(8'hC3);
    for (int i = 0; i < W; i++) begin mode = 2'd2; tick(); end
    chk("rmid_done", 32'(done), 32'h1);
    rst_n = 1'b0; mode = 2'd1; tick();
    chk("rmid_done_clr", 32'(done), 32'h0);
    chk("rmid_q", 32'(q), 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < W; i++) begin
      mode = 2'd1; tick();
      chk("rmid_restart", 32'(done), (i == W - 1) ? 32'h1 : 32'h0);
    end

`ifdef SHIFTREG_ROTATE_EN
    load(8'h01);
    rot = 1'b1; mode = 2'd1; sin_r = 1'b0; tick();
    chk("rot_q1", 32'(q), 32'h80);
    for (int i = 0; i < 7; i++) tick();
    chk("rot_q8", 32'(q), 32'h01);
    chk("rot_done", 32'(done), 32'h1);
    rot = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && mode == 2'd3) mode = 2'($urandom_range(1, 2));
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      d     = 8'($urandom);
      rot   = ROT_ON ? 1'($urandom) : 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
